// File: rtl/icache_axi_refill.sv
// AXI4 read responder for icache line refills (8-beat INCR -> 256-bit line).
// Optional uncached word fetch path: define ICACHE_REFILL_UNCACHE_EN.
module icache_axi_refill #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    branch_flush,
  input  logic                    rd_req,
  input  logic [31:0]             rd_addr,
  output logic                    ret_valid,
  output logic [32*LINE_WORDS-1:0] ret_data,
  input  logic                    iucache_ren_i,
  input  logic [31:0]             iucache_addr_i,
  output logic                    iucache_rvalid_o,
  output logic [31:0]             iucache_rdata_o,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int          CW       = $clog2(LINE_WORDS);
  localparam logic [31:0] OFF_MASK = 32'(LINE_WORDS*4 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_RESP,
    S_DRAIN,
    S_UAR,
    S_UR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            flush_q;
  logic [31:0]     araddr_q;
  logic [7:0]      arlen_q;
  logic [31:0]     line_q [LINE_WORDS];
  logic            in_r, beat, start_c, wr_c;

  // Error responses carry no meaning for instruction fetch here
  logic unused;
  assign unused = ^rresp;

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arvalid = (state_q == S_AR) || (state_q == S_UAR);

  assign in_r = (state_q == S_R) || (state_q == S_DRAIN) ||
                (state_q == S_UR);
  // Foreign-ID beats are left on the bus for their owner
  assign rready = in_r && (!rvalid || rid == AXI_ID);
  assign beat   = rvalid && rready;

  assign ret_valid = (state_q == S_RESP) && !branch_flush;
  assign start_c   = (state_q == S_IDLE) && (state_d == S_AR);
  assign wr_c      = (state_q == S_R) && beat && !branch_flush;

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
    assign ret_data[32*g +: 32] = line_q[g];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!branch_flush) begin
          if (rd_req) state_d = S_AR;
`ifdef ICACHE_REFILL_UNCACHE_EN
          else if (iucache_ren_i) state_d = S_UAR;
`endif
        end
      end
      S_AR: begin
        if (arready)
          state_d = (flush_q || branch_flush) ? S_DRAIN : S_R;
      end
      S_UAR: begin
        if (arready)
          state_d = (flush_q || branch_flush) ? S_DRAIN : S_UR;
      end
      S_R: begin
        if (branch_flush)
          state_d = (beat && rlast) ? S_IDLE : S_DRAIN;
        else if (beat && rlast)
          state_d = S_RESP;
      end
      S_UR: begin
        if (beat)
          state_d = S_IDLE;
        else if (branch_flush)
          state_d = S_DRAIN;
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: begin
        if (beat && rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (start_c) begin
        araddr_q <= rd_addr & ~OFF_MASK;
        arlen_q  <= 8'(LINE_WORDS - 1);
        cnt_q    <= '0;
        flush_q  <= 1'b0;
      end
`ifdef ICACHE_REFILL_UNCACHE_EN
      if (state_q == S_IDLE && state_d == S_UAR) begin
        araddr_q <= iucache_addr_i;
        arlen_q  <= '0;
        flush_q  <= 1'b0;
      end
`endif
      if (arvalid && branch_flush) flush_q <= 1'b1;
      if (wr_c) begin
        line_q[cnt_q] <= rdata;
        cnt_q         <= cnt_q + 1'b1;
      end
    end
  end

`ifdef ICACHE_REFILL_UNCACHE_EN
  logic        urvalid_q;
  logic [31:0] urdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      urvalid_q <= 1'b0;
      urdata_q  <= '0;
    end else begin
      urvalid_q <= (state_q == S_UR) && beat && !branch_flush;
      if ((state_q == S_UR) && beat && !branch_flush)
        urdata_q <= rdata;
    end
  end

  assign iucache_rvalid_o = urvalid_q;
  assign iucache_rdata_o  = urdata_q;
`else
  logic unused_u;
  assign unused_u = ^{iucache_ren_i, iucache_addr_i};
  assign iucache_rvalid_o = 1'b0;
  assign iucache_rdata_o  = '0;
`endif

endmodule

// File: tb/tb_icache_axi_refill.sv
// Scoreboard bench for icache_axi_refill: directed AXI bursts,
// flush/reset aborts, short bursts and the uncached path.
module tb_icache_axi_refill;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         branch_flush = 1'b0;
  logic         rd_req = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic         iucache_ren_i = 1'b0;
  logic [31:0]  iucache_addr_i = '0;
  logic         iucache_rvalid_o;
  logic [31:0]  iucache_rdata_o;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [3:0]   rid = '0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;

  icache_axi_refill dut (
    .clk              (clk),
    .reset            (reset),
    .branch_flush     (branch_flush),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .ret_valid        (ret_valid),
    .ret_data         (ret_data),
    .iucache_ren_i    (iucache_ren_i),
    .iucache_addr_i   (iucache_addr_i),
    .iucache_rvalid_o (iucache_rvalid_o),
    .iucache_rdata_o  (iucache_rdata_o),
    .arid             (arid),
    .araddr           (araddr),
    .arlen            (arlen),
    .arsize           (arsize),
    .arburst          (arburst),
    .arvalid          (arvalid),
    .arready          (arready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .rvalid           (rvalid),
    .rready           (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  logic [31:0]  uq[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           t_req = 0;
  logic [31:0]  bd [8];
  logic [255:0] line;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && ret_valid) begin
      if (sb.size() == 0) chk("unexpected_ret_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("ret_data", ret_data, e.data);
        if (e.lat >= 0) chk("latency", cyc - t_req, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] u;
    if (reset && iucache_rvalid_o) begin
      if (uq.size() == 0) chk("unexpected_urvalid", 1, 0);
      else begin
        u = uq.pop_front();
        chk("iucache_rdata", iucache_rdata_o, u);
      end
    end
  end

  task automatic wait_arvalid();
    int n = 0;
    while (!arvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("arvalid_seen", arvalid, 1);
  endtask

  task automatic ar_hs(input int delay, input logic [31:0] ea,
                       input logic [7:0] el, input int flush_k);
    wait_arvalid();
    chk("araddr", araddr, ea);
    chk("arlen", arlen, el);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    for (int k = 0; k < delay; k++) begin
      branch_flush = (k == flush_k);
      @(posedge clk); #1;
      branch_flush = 1'b0;
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, ea);
    end
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 0);
  endtask

  task automatic send_beats(input int n, input int gap,
                            input int flush_at, input bit last);
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        rvalid = 1'b0;
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rid    = 4'd0;
      rdata  = bd[i];
      rlast  = last && (i == n - 1);
      rresp  = (i == 1) ? 2'b10 : 2'b00;
      branch_flush = (i == flush_at);
      #1;
      chk("rready", rready, 1);
      @(posedge clk); #1;
      branch_flush = 1'b0;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic start_req(input logic [31:0] a);
    rd_addr = a;
    rd_req  = 1'b1;
    t_req   = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_data", ret_data, 0);
    chk("rst_rready", rready, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: zero-wait full line
    for (int i = 0; i < 8; i++) bd[i] = 32'h11 * (i + 1);
    line = {32'h88, 32'h77, 32'h66, 32'h55,
            32'h44, 32'h33, 32'h22, 32'h11};
    sb.push_back('{line, 10});
    start_req(32'h1C00_0024);
    ar_hs(0, 32'h1C00_0020, 8'd7, -1);
    send_beats(8, 0, -1, 1);
    rd_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 2: slow AR, every-other-cycle beats, foreign RID first
    for (int i = 0; i < 8; i++) bd[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 8; i++) line[32*i +: 32] = bd[i];
    sb.push_back('{line, -1});
    start_req(32'h0000_1040);
    ar_hs(5, 32'h0000_1040, 8'd7, -1);
    rvalid = 1'b1;
    rid    = 4'd5;
    rdata  = 32'hBAD0_BAD0;
    #1;
    chk("rready_foreign_id", rready, 0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    rid    = 4'd0;
    send_beats(8, 1, -1, 1);
    rd_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // short burst: only words 0..2 replaced
    for (int i = 0; i < 3; i++) bd[i] = 32'h5000_0000 + i;
    for (int i = 0; i < 3; i++) line[32*i +: 32] = bd[i];
    sb.push_back('{line, -1});
    start_req(32'h0000_2000);
    ar_hs(0, 32'h0000_2000, 8'd7, -1);
    send_beats(3, 0, -1, 1);
    rd_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 3: flush on 3rd beat, then normal refill
    for (int i = 0; i < 8; i++) bd[i] = 32'hF000_0000 + i;
    start_req(32'h1C00_0080);
    ar_hs(0, 32'h1C00_0080, 8'd7, -1);
    send_beats(8, 0, 2, 1);
    rd_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) bd[i] = 32'h3300_0000 + i;
    for (int i = 0; i < 8; i++) line[32*i +: 32] = bd[i];
    sb.push_back('{line, -1});
    start_req(32'h1C00_0100);
    ar_hs(0, 32'h1C00_0100, 8'd7, -1);
    send_beats(8, 0, -1, 1);
    rd_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 4: flush while AR waits; line must stay untouched
    for (int i = 0; i < 8; i++) bd[i] = 32'hEE00_0000 + i;
    start_req(32'h1C00_0200);
    ar_hs(3, 32'h1C00_0200, 8'd7, 0);
    send_beats(8, 0, -1, 1);
    rd_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("drain_keeps_line", ret_data, line);

    // 5: async reset mid-burst
    start_req(32'h1C00_0300);
    ar_hs(0, 32'h1C00_0300, 8'd7, -1);
    send_beats(4, 0, -1, 0);
    reset  = 1'b0;
    rd_req = 1'b0;
    #1;
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_ret_data", ret_data, 0);
    chk("mid_rst_araddr", araddr, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", arvalid, 0);
    for (int i = 0; i < 8; i++) bd[i] = 32'h7000_0000 + i;
    for (int i = 0; i < 8; i++) line[32*i +: 32] = bd[i];
    sb.push_back('{line, 10});
    start_req(32'h1C00_0400);
    ar_hs(0, 32'h1C00_0400, 8'd7, -1);
    send_beats(8, 0, -1, 1);
    rd_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 6: uncached word fetch
`ifdef ICACHE_REFILL_UNCACHE_EN
    bd[0] = 32'hDEAD_BEEF;
    uq.push_back(32'hDEAD_BEEF);
    iucache_addr_i = 32'hBFD0_0004;
    iucache_ren_i  = 1'b1;
    ar_hs(0, 32'hBFD0_0004, 8'd0, -1);
    send_beats(1, 0, -1, 1);
    iucache_ren_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("urvalid_pulse", iucache_rvalid_o, 0);
`else
    iucache_addr_i = 32'hBFD0_0004;
    iucache_ren_i  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("uncache_ignored", arvalid, 0);
      chk("urvalid_tied", iucache_rvalid_o, 0);
    end
    iucache_ren_i = 1'b0;
`endif

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    chk("uq_empty", uq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
